// File: rtl/vigenere_stream_cipher.sv
// Purpose: generic synchronous FIFO, no push/pop bypass, synchronous flush.
// Latency: a pushed entry is visible at pop_dat one edge after the push.
// Backpressure: push_rdy drops when full; pop only honoured while pop_vld.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push     = push_vld && push_rdy && !clr;
    assign pop      = pop_rdy && pop_vld && !clr;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Purpose: buffered Vigenere encrypt/decrypt of an ASCII char stream with a stored key.
// Latency: char pushed on edge N into an idle path is presented after edge N+1.
// Backpressure: out_ready stalls the output register, then the FIFO, then in_ready.
module vigenere_stream_cipher #(
    parameter int KEY_LEN    = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int KW = $clog2(KEY_LEN + 1),
    localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_wr,
    input  logic [7:0]    key_char,
    input  logic          key_done,
    input  logic          key_clear,
    input  logic          mode,
    input  logic          in_valid,
    input  logic [7:0]    in_char,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_char,
    input  logic          out_ready,
    output logic          running,
    output logic [FW-1:0] fifo_count,
    output logic [KW-1:0] key_count,
    output logic          overflow
);
    typedef enum logic {KEY_ENTRY = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [4:0]    key_shift [2**KW];
    logic [KW-1:0] idx_q;
    logic          key_wr_en;
    logic          fifo_push_rdy;
    logic          fifo_pop_vld;
    logic [7:0]    fifo_dat;
    logic          load;
    logic          is_letter;
    logic [7:0]    cipher_char;

    function automatic logic [4:0] letter_shift(input logic [7:0] c);
        logic [7:0] d;
        d = 8'h00;
        if (c >= 8'h41 && c <= 8'h5A)      d = c - 8'h41;
        else if (c >= 8'h61 && c <= 8'h7A) d = c - 8'h61;
        return d[4:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= KEY_ENTRY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (key_clear)                            state_d = KEY_ENTRY;
        else if (state_q == KEY_ENTRY && key_done) state_d = RUN;
    end

    always_comb begin
        running  = (state_q == RUN);
        in_ready = (state_q == RUN) && fifo_push_rdy;
    end

    assign key_wr_en = !key_clear && (state_q == KEY_ENTRY) && key_wr && (key_count < KW'(KEY_LEN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         key_count <= '0;
        else if (key_clear) key_count <= '0;
        else if (key_wr_en) key_count <= key_count + KW'(1);
    end

    always_ff @(posedge clk) begin
        if (key_wr_en) key_shift[key_count] <= letter_shift(key_char);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (key_clear),
        .push_vld (running && in_valid && !key_clear),
        .push_dat (in_char),
        .push_rdy (fifo_push_rdy),
        .pop_rdy  (load),
        .pop_vld  (fifo_pop_vld),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    assign load = fifo_pop_vld && (!out_valid || out_ready) && !key_clear;

    // Encrypt sum needs a sixth bit: p+k reaches 50 before the mod-26 fold.
    always_comb begin
        logic       is_up;
        logic [7:0] base;
        logic [7:0] off;
        logic [4:0] p;
        logic [4:0] k;
        logic [5:0] sum;
        logic [4:0] r;
        is_up     = (fifo_dat >= 8'h41 && fifo_dat <= 8'h5A);
        is_letter = is_up || (fifo_dat >= 8'h61 && fifo_dat <= 8'h7A);
        base      = is_up ? 8'h41 : 8'h61;
        off       = fifo_dat - base;
        p         = off[4:0];
        k         = (key_count != '0) ? key_shift[idx_q] : 5'd0;
        sum       = {1'b0, p} + {1'b0, k};
        r         = 5'd0;
        if (mode) r = (p >= k) ? (p - k) : (p - k + 5'd26);
        else      r = (sum >= 6'd26) ? 5'(sum - 6'd26) : sum[4:0];
        cipher_char = is_letter ? (base + {3'b000, r}) : fifo_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else if (key_clear) begin
            idx_q <= '0;
        end else if (load && is_letter && key_count != '0) begin
            idx_q <= (idx_q == key_count - KW'(1)) ? '0 : idx_q + KW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_char  <= 8'h00;
        end else if (key_clear) begin
            out_valid <= 1'b0;
            out_char  <= 8'h00;
        end else if (load) begin
            out_valid <= 1'b1;
            out_char  <= cipher_char;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  overflow <= 1'b0;
        else if (key_clear)                          overflow <= 1'b0;
        else if (running && in_valid && !in_ready)   overflow <= 1'b1;
    end
endmodule
